// File: rtl/apb_template_slave.sv
// Zero-wait-state APB register bank: N_REGS word registers starting at BASE_ADDR.
// An out-of-range access returns zero data and raises pslverr in its access cycle.
module apb_template_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int          DATA_WIDTH = 32,
  parameter int          N_REGS     = 8
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [31:0]             paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int          IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * N_REGS);

  logic [DATA_WIDTH-1:0] regs [N_REGS];
  logic [31:0]           offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  wr_commit;

  // The offset is compared instead of BASE_ADDR+SPAN, which could wrap at the top of the map.
  assign offset    = paddr - BASE_ADDR;
  assign in_range  = (paddr >= BASE_ADDR) && (offset < SPAN);
  assign idx       = offset[IDX_W+1:2];
  assign wr_commit = psel && penable && pwrite && in_range;

  // Every write is a full word; protection and strobes carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{pprot, pstrb, offset};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order of the statements.
  // NOTE: the register array is explicitly cleared because software expects
  // zeros after reset; reset is tested first, so a same-cycle write is dropped.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int k = 0; k < N_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_commit) begin
      regs[idx] <= pwdata;
    end
  end

  assign pready  = psel && penable;
  assign pslverr = psel && penable && !in_range;

  // Read data is valid from the setup cycle onward and depends only on the
  // bus inputs, so it stays stable through the closing edge.
  // NOTE: the output is given a default before the branch so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite && in_range) begin
      prdata = regs[idx];
    end
  end

endmodule

// File: tb/tb_apb_template_slave.sv
// Directed bench for apb_template_slave with BASE_ADDR=8, N_REGS=8: normal,
// gapped, out-of-range, reset and zero-strobe traffic against hand-computed values.
module tb_apb_template_slave;

  localparam logic [31:0] BASE = 32'd8;
  localparam int          NR   = 8;
  localparam int          DW   = 32;

  logic            pclk;
  logic            preset;
  logic [31:0]     paddr;
  logic [2:0]      pprot;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;
  int err_mark;

  apb_template_slave #(
    .BASE_ADDR  (BASE),
    .DATA_WIDTH (DW),
    .N_REGS     (NR)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .pprot   (pprot),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Counts cycles in which an error response is presented at a closing edge.
  always @(posedge pclk) begin
    if (pslverr === 1'b1) err_cycles <= err_cycles + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, observed still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic go_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge pclk);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic exp_err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = addr; pwdata = data; pstrb = strb;
    #1;
    check($sformatf("wr_setup_pready@%0d", addr), 32'(pready), 32'd0);
    check($sformatf("wr_setup_pslverr@%0d", addr), 32'(pslverr), 32'd0);
    @(negedge pclk);
    penable = 1'b1;
    #1;
    check($sformatf("wr_access_pready@%0d", addr), 32'(pready), 32'd1);
    check($sformatf("wr_access_pslverr@%0d", addr), 32'(pslverr), 32'(exp_err));
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = addr; pwdata = 32'hFFFF_FFFF;
    #1;
    check($sformatf("rd_setup_prdata@%0d", addr), prdata, exp_data);
    check($sformatf("rd_setup_pslverr@%0d", addr), 32'(pslverr), 32'd0);
    @(negedge pclk);
    penable = 1'b1;
    #1;
    check($sformatf("rd_access_prdata@%0d", addr), prdata, exp_data);
    check($sformatf("rd_access_pready@%0d", addr), 32'(pready), 32'd1);
    check($sformatf("rd_access_pslverr@%0d", addr), 32'(pslverr), 32'(exp_err));
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'hF; pprot = 3'b000;

    // Reset state: idle bus, all combinational outputs low.
    go_idle(3);
    #1;
    check("reset_pready", 32'(pready), 32'd0);
    check("reset_pslverr", 32'(pslverr), 32'd0);
    check("reset_prdata", prdata, 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    go_idle(1);

    // Fresh registers read zero, including the first and last ones.
    apb_read(32'd8, 32'd0, 1'b0);
    apb_read(32'd36, 32'd0, 1'b0);
    go_idle(1);

    // Back-to-back writes of data=addr, then back-to-back reads.
    for (int a = 8; a <= 36; a += 4) apb_write(32'(a), 32'(a), 4'hF, 1'b0);
    for (int a = 8; a <= 36; a += 4) apb_read(32'(a), 32'(a), 1'b0);
    // Low address bits are ignored inside the window.
    apb_read(32'd11, 32'd8, 1'b0);
    apb_read(32'd39, 32'd36, 1'b0);
    go_idle(1);

    // Writes of addr-8 separated by 60 ns gaps, then gapped reads.
    for (int a = 8; a <= 36; a += 4) begin
      apb_write(32'(a), 32'(a - 8), 4'hF, 1'b0);
      go_idle(6);
    end
    for (int a = 8; a <= 36; a += 4) begin
      apb_read(32'(a), 32'(a - 8), 1'b0);
      go_idle(6);
    end

    // Out-of-range writes just below and just above the window.
    err_mark = err_cycles;
    apb_write(32'd7, 32'd234, 4'hF, 1'b1);
    apb_write(32'd40, 32'd124, 4'hF, 1'b1);
    go_idle(1);
    for (int a = 8; a <= 36; a += 4) apb_read(32'(a), 32'(a - 8), 1'b0);

    // Out-of-range reads return zero with an error response.
    apb_read(32'd7, 32'd0, 1'b1);
    apb_read(32'd40, 32'd0, 1'b1);
    go_idle(2);
    check("error_cycle_count", 32'(err_cycles - err_mark), 32'd4);

    // Reset with a write in flight: everything clears, the write is dropped.
    @(negedge pclk);
    preset = 1'b1;
    apb_write(32'd12, 32'h0000_0055, 4'hF, 1'b0);
    go_idle(1);
    @(negedge pclk);
    preset = 1'b0;
    for (int a = 8; a <= 36; a += 4) apb_read(32'(a), 32'd0, 1'b0);
    go_idle(1);

    // Zero strobes still write the full word.
    apb_write(32'd12, 32'hDEAD_BEEF, 4'h0, 1'b0);
    apb_read(32'd12, 32'hDEAD_BEEF, 1'b0);
    apb_read(32'd16, 32'd0, 1'b0);
    go_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_template_slave.md
APB_TEMPLATE_SLAVE -- requirements
Module: apb_template_slave

Interface
REQ-001 Parameter BASE_ADDR, default 0, byte address of register 0; a multiple of 4.
REQ-002 Parameter DATA_WIDTH, default 32, register and data-bus width in bits.
REQ-003 Parameter N_REGS, default 8, number of registers; register k is at BASE_ADDR+4*k.
REQ-004 pclk  in  1  single clock; all state updates on the rising edge.
REQ-005 preset  in  1  reset; synchronous and active-high.
REQ-006 paddr  in  32  APB byte address.
REQ-007 pprot  in  3  protection type; ignored.
REQ-008 psel  in  1  slave select.
REQ-009 penable  in  1  access-phase indicator.
REQ-010 pwrite  in  1  1 = write, 0 = read.
REQ-011 pwdata  in  DATA_WIDTH  write data.
REQ-012 pstrb  in  DATA_WIDTH/8  write strobes; ignored; every write is full-word, including pstrb = 0.
REQ-013 pready  out  1  transfer-complete indicator.
REQ-014 prdata  out  DATA_WIDTH  read data.
REQ-015 pslverr  out  1  transfer error.

Function
REQ-016 Storage SHALL be N_REGS registers of DATA_WIDTH bits.
REQ-017 in_range SHALL be BASE_ADDR <= paddr < BASE_ADDR+4*N_REGS, compared as unsigned 32-bit values.
REQ-018 Register index SHALL be (paddr-BASE_ADDR)>>2; paddr[1:0] ignored when in range.
REQ-019 Transfer sequence, standard APB: setup cycle (psel=1, penable=0), then access cycle (psel=1, penable=1).
REQ-020 Zero wait states: pready SHALL be combinational, pready = psel & penable.
REQ-021 Write commit on the rising edge ending the access cycle when psel & penable & pwrite & in_range: reg[index] <= pwdata.
REQ-022 A write with in_range = 0 SHALL modify no register.
REQ-023 prdata SHALL be combinational: reg[index] when psel & !pwrite & in_range, else 0.
REQ-024 prdata SHALL be valid in both setup and access cycles and stable through the closing clock edge.
REQ-025 Reads SHALL have no side effects.
REQ-026 pslverr SHALL be combinational, pslverr = psel & penable & !in_range; asserted for exactly the access cycle of an out-of-range transfer.
REQ-027 pslverr SHALL be 0 in setup cycles, in idle, and for all in-range transfers.
REQ-028 Back-to-back transfers SHALL be supported: a setup cycle may immediately follow an access cycle.
REQ-029 Idle gaps of any length between transfers SHALL not alter stored data.
REQ-030 Writing one register SHALL not affect any other register.

Reset
REQ-031 While preset = 1 at a rising edge, every register SHALL be cleared to 0; a write in the same cycle is discarded (reset has priority).
REQ-032 pready, prdata and pslverr SHALL be purely combinational, so they follow the rules above even during reset.
REQ-033 After reset is released, a read of any register SHALL return 0 until that register is written.

Verification
REQ-034 Use BASE_ADDR=8, N_REGS=8. Back-to-back writes of data=addr to addresses 8..36 step 4, then back-to-back reads -> each read returns its address; pslverr = 0 throughout.
REQ-035 Write data=addr-8 to addresses 8..36, each followed by an idle gap of 50+ ns -> reads, also separated by gaps, return 0,4,...,28.
REQ-036 Write 234 to address 7 and 124 to address 40 -> pslverr = 1 only in each access cycle; all registers unchanged.
REQ-037 Read from address 7 and from address 40 -> pslverr = 1 in each access cycle, prdata = 0; exactly 4 error cycles over REQ-036 and REQ-037.
REQ-038 Assert preset after registers are written -> all registers read back 0; a write issued during reset is not stored.
REQ-039 A write with pstrb = 0 to address 12 of 0xDEADBEEF -> a read of address 12 returns 0xDEADBEEF.
